digit_serial_adder: RTL and testbench

Parametrised, sequential successor to the 6-bit combinational `adder`. Adds two unsigned WIDTH-bit operands DIGIT bits per clock, LSB digit first, with a registered carry between digits. Produces a (WIDTH+1)-bit sum behind a valid/ready handshake. With the default parameters its results match the existing 4096-vector `data.txt` golden file.

---
 rtl/adder_pkg.sv | 24 ++
 rtl/digit_adder.sv | 35 +++
 rtl/digit_serial_adder.sv | 220 ++++++++++++++++++++++
 tb/tb_digit_serial_adder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the digit-serial adder:
//   state_e    - FSM states of the top-level sequencer (IDLE, RUN, DONE)
//   cnt_width  - width of a counter that indexes n digit steps, $clog2(n) with
//                a floor of one bit so that n == 1 still yields a real signal
// -----------------------------------------------------------------------------
package adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int cnt_width(input int n);
      if (n <= 1) begin
         cnt_width = 1;
      end else begin
         cnt_width = $clog2(n);
      end
   endfunction

endpackage

// File: rtl/digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
// Combinational DIGIT-bit ripple-carry slice. One instance is time-shared by
// the digit-serial adder, one digit per clock.
// Ports:
//   a, b  in  DIGIT  operand digits (b already inverted by the caller for sub)
//   cin   in  1      carry into the least significant bit
//   sum   out DIGIT  digit sum
//   cout  out 1      carry out of the most significant bit
// -----------------------------------------------------------------------------
module digit_adder #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout
);

   logic [DIGIT:0] carry_s;

   // Bit-by-bit ripple chain; carry_s[i] is the carry into bit i.
   always_comb begin
      carry_s    = {(DIGIT+1){1'b0}};
      sum        = {DIGIT{1'b0}};
      carry_s[0] = cin;
      for (int i = 0; i < DIGIT; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry_s[i];
         carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
      end
      cout = carry_s[DIGIT];
   end

endmodule

// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
// Adds two unsigned WIDTH-bit operands DIGIT bits per clock, least significant
// digit first, with the carry held in a register between digits. The
// (WIDTH+1)-bit result is offered behind a valid/ready handshake.
//
// Optional feature macro: ADDER_SUB_EN
//   defined   - adds the `sub` port; sub=1 computes x-y as a (WIDTH+1)-bit
//               two's-complement value, s[WIDTH] being the borrow
//   undefined - add only, s[WIDTH] is the carry out
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous active-high reset
//   in_valid   in   1        operands presented
//   in_ready   out  1        block can accept operands (state IDLE)
//   x, y       in   WIDTH    operands, latched at accept
//   sub        in   1        subtract select (ADDER_SUB_EN only)
//   out_valid  out  1        result available (state DONE)
//   out_ready  in   1        consumer takes the result
//   s          out  WIDTH+1  result, held stable while out_valid
//   busy       out  1        high in RUN and DONE
// -----------------------------------------------------------------------------
module digit_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 6,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
`ifdef ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   s,
   output logic             busy
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = cnt_width(N);
   // Index width for bit positions inside an operand.
   localparam int IW = cnt_width(WIDTH);

   // The operand must split into whole digits.
   if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             sub_q, sub_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   s_q, s_d;

   logic             sub_in_s;
   logic             last_s;
   logic [IW-1:0]    base_s;
   logic [DIGIT-1:0] a_dig_s;
   logic [DIGIT-1:0] b_dig_s;
   logic [DIGIT-1:0] sum_dig_s;
   logic             cout_s;

`ifdef ADDER_SUB_EN
   assign sub_in_s = sub;
`else
   assign sub_in_s = 1'b0;
`endif

   assign last_s = (cnt_q == CW'(N - 1));
   assign base_s = IW'(cnt_q) * IW'(DIGIT);

   // Select digit k of the latched operands; y is inverted for subtraction.
   always_comb begin
      a_dig_s = x_q[base_s +: DIGIT];
      b_dig_s = y_q[base_s +: DIGIT] ^ {DIGIT{sub_q}};
   end

   digit_adder #(
      .DIGIT (DIGIT)
   ) u_digit_adder (
      .a    (a_dig_s),
      .b    (b_dig_s),
      .cin  (carry_q),
      .sum  (sum_dig_s),
      .cout (cout_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode: every handshake output comes straight from the state flop.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
         end
         ST_RUN: begin
            busy = 1'b1;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   assign s = s_q;

   // Datapath next values: latch at accept, one digit per RUN cycle.
   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               x_d     = x;
               y_d     = y;
               sub_d   = sub_in_s;
               // x - y = x + ~y + 1, so the carry is seeded with the sub flag.
               carry_d = sub_in_s;
               cnt_d   = {CW{1'b0}};
            end else begin
               cnt_d   = cnt_q;
            end
         end
         ST_RUN: begin
            s_d[base_s +: DIGIT] = sum_dig_s;
            carry_d              = cout_s;
            if (last_s) begin
               // Borrow is the inverse of the final carry in subtract mode.
               s_d[WIDTH] = cout_s ^ sub_q;
               cnt_d      = {CW{1'b0}};
            end else begin
               cnt_d      = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            s_d = s_q;
         end
         default: begin
            cnt_d = {CW{1'b0}};
         end
      endcase
   end

   // Operand, carry, counter and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q     <= {WIDTH{1'b0}};
         y_q     <= {WIDTH{1'b0}};
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= {CW{1'b0}};
         s_q     <= {(WIDTH+1){1'b0}};
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
      end
   end

endmodule

// File: tb/tb_digit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_digit_serial_adder
// Randomised scoreboard bench for digit_serial_adder. The driver issues
// operations and pushes the arithmetic result and the accept cycle; a monitor
// drives out_ready and compares whenever out_valid is presented.
// Build with -DADDER_SUB_EN to exercise subtraction.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_digit_serial_adder;

   parameter int WIDTH = 6;
   parameter int DIGIT = 2;
   localparam int N = WIDTH / DIGIT;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x_i;
   logic [WIDTH-1:0] y_i;
   logic             sub_i;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   s;
   logic             busy;

   digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x_i),
      .y         (y_i),
`ifdef ADDER_SUB_EN
      .sub       (sub_i),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int bp_hold = 0;
   bit bp_rand = 1'b0;

   logic [WIDTH:0] sb_q[$];
   int             acc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic reduced modulo 2^(WIDTH+1).
   function automatic logic [WIDTH:0] ref_model(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic sb);
      longint r;
      if (sb) r = longint'(a) - longint'(b);
      else    r = longint'(a) + longint'(b);
      return r[WIDTH:0];
   endfunction

   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sb, input bit track);
      int guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         // Scramble the ports while the block is busy; they must be ignored.
         x_i      = WIDTH'($urandom);
         y_i      = WIDTH'($urandom);
         sub_i    = 1'($urandom_range(0, 1));
         in_valid = 1'($urandom_range(0, 1));
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         chk("issue_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      x_i      = a;
      y_i      = b;
      sub_i    = sb;
      in_valid = 1'b1;
      if (track) begin
         sb_q.push_back(ref_model(a, b, sb));
         acc_q.push_back(cyc + 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      x_i      = WIDTH'($urandom);
      y_i      = WIDTH'($urandom);
   endtask

   task automatic drain();
      int guard = 0;
      while ((sb_q.size() != 0 || !in_ready) && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (sb_q.size() != 0 || !in_ready) chk("drain_timeout", 0, 1);
   endtask

   // Monitor: owns out_ready, compares each presented result with the scoreboard.
   initial begin : monitor
      bit seen   = 1'b0;
      bit handed = 1'b0;
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            seen   = 1'b0;
            handed = 1'b0;
         end else begin
            if (handed) begin
               chk("in_ready_after_handoff", in_ready, 1);
               chk("out_valid_after_handoff", out_valid, 0);
               handed = 1'b0;
            end
            if (out_valid) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_output", 1, 0);
                  out_ready = 1'b1;
               end else begin
                  if (!seen) begin
                     seen = 1'b1;
                     chk("result", s, sb_q[0]);
                     chk("latency", cyc - acc_q[0], N);
                     chk("busy_in_done", busy, 1);
                     chk("in_ready_in_done", in_ready, 0);
                  end
                  if (bp_hold > 0) begin
                     out_ready = 1'b0;
                     bp_hold--;
                  end else if (bp_rand) begin
                     out_ready = 1'($urandom_range(0, 1));
                  end else begin
                     out_ready = 1'b1;
                  end
                  if (out_ready) begin
                     chk("result_stable", s, sb_q[0]);
                     void'(sb_q.pop_front());
                     void'(acc_q.pop_front());
                     seen   = 1'b0;
                     handed = 1'b1;
                  end
               end
            end else begin
               // out_ready outside DONE must have no effect.
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   initial begin : main
      logic [WIDTH-1:0] ones;
      logic             sb;
      ones     = {WIDTH{1'b1}};
      rst      = 1'b1;
      in_valid = 1'b0;
      x_i      = {WIDTH{1'b0}};
      y_i      = {WIDTH{1'b0}};
      sub_i    = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_s", s, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_busy", busy, 0);

      // Corners.
      issue(ones, ones, 1'b0, 1'b1);
      issue({WIDTH{1'b0}}, {WIDTH{1'b0}}, 1'b0, 1'b1);
      issue(WIDTH'(37), WIDTH'(26), 1'b0, 1'b1);
      drain();

      // Backpressure: consumer stalls for 5 cycles.
      bp_hold = 5;
      issue(WIDTH'(20), WIDTH'(5), 1'b0, 1'b1);
      drain();

      // Reset one cycle after accept; the aborted result must never appear.
      issue(WIDTH'(15), WIDTH'(15), 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_s", s, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_busy", busy, 0);
      issue(WIDTH'(1), WIDTH'(1), 1'b0, 1'b1);
      drain();

`ifdef ADDER_SUB_EN
      issue(WIDTH'(0), WIDTH'(1), 1'b1, 1'b1);
      issue(WIDTH'(40), WIDTH'(8), 1'b1, 1'b1);
      drain();
`endif

      // Exhaustive sweep for small widths, consumer always ready.
      if (WIDTH <= 6) begin
         for (int a = 0; a < (1 << WIDTH); a++) begin
            for (int b = 0; b < (1 << WIDTH); b++) begin
               issue(WIDTH'(a), WIDTH'(b), 1'b0, 1'b1);
            end
         end
         drain();
      end

      // Random operands, random mode, random backpressure.
      bp_rand = 1'b1;
      for (int i = 0; i < 300; i++) begin
`ifdef ADDER_SUB_EN
         sb = 1'($urandom_range(0, 1));
`else
         sb = 1'b0;
`endif
         issue(WIDTH'($urandom), WIDTH'($urandom), sb, 1'b1);
      end
      drain();
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
